// File: rtl/glove_rx_decoder.sv
// glove_rx_decoder: host-side receiver for the glove command link.
// Deserializes the 8N1 stream on rx and decodes command bytes 0..8. It keeps
// a saturating cursor position and emits one-cycle click/scroll strobes.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active low
//   rx           asynchronous serial input, idle high
//   cursor_x/y   registered cursor position (10 bits each)
//   cmd_valid    one-cycle strobe per well-framed byte, with cmd = that byte
//   click        one-cycle strobe on command 4
//   scroll_up    one-cycle strobe on command 6
//   scroll_down  one-cycle strobe on command 7
//   bad_cmd      one-cycle strobe on framed byte 5 or 9..255
//   frame_err    one-cycle strobe when the stop bit samples low
module glove_rx_decoder #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned STEP     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [9:0] cursor_x,
  output logic [9:0] cursor_y,
  output logic       cmd_valid,
  output logic [7:0] cmd,
  output logic       click,
  output logic       scroll_up,
  output logic       scroll_down,
  output logic       bad_cmd,
  output logic       frame_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned POS_W        = 10;
  localparam int unsigned ARITH_W      = 11;

  localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [ARITH_W-1:0] X_MAX     = ARITH_W'(SCREEN_W - 1);
  localparam logic [ARITH_W-1:0] Y_MAX     = ARITH_W'(SCREEN_H - 1);
  localparam logic [ARITH_W-1:0] STEP_A    = ARITH_W'(STEP);
  localparam logic [POS_W-1:0]   X_CTR     = POS_W'(SCREEN_W / 2);
  localparam logic [POS_W-1:0]   Y_CTR     = POS_W'(SCREEN_H / 2);

  typedef enum logic [2:0] {
    S_ARM,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic               rx_meta;
  logic               line;
  logic               done;     // stop bit sampled this cycle
  logic               done_ok;  // ...and it was high

  // Saturating step toward zero.
  function automatic logic [POS_W-1:0] sat_dec(input logic [POS_W-1:0] v);
    logic [ARITH_W-1:0] w;
    w = ARITH_W'(v);
    if (w < STEP_A) return '0;
    return POS_W'(w - STEP_A);
  endfunction

  // Saturating step toward lim.
  function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] v,
                                                input logic [ARITH_W-1:0] lim);
    logic [ARITH_W-1:0] w;
    w = ARITH_W'(v) + STEP_A;
    if (w > lim) return POS_W'(lim);
    return POS_W'(w);
  endfunction

  // Two-flop synchronizer; resets to the idle level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      line    <= 1'b1;
    end else begin
      rx_meta <= rx;
      line    <= rx_meta;
    end
  end

  // Receiver FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_ARM;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      done    <= 1'b0;
      done_ok <= 1'b0;
    end else begin
      done    <= 1'b0;
      done_ok <= 1'b0;
      case (state)
        // Require a full bit time of continuous high before listening.
        S_ARM: begin
          if (!line) begin
            cnt <= '0;
          end else if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_IDLE: begin
          if (!line) begin
            cnt   <= '0;
            state <= S_START;
          end
        end
        // Mid-start-bit check rejects short glitches.
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!line) begin
              bit_idx <= '0;
              state   <= S_DATA;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {line, shreg[7:1]};
            if (bit_idx == 3'd7) state <= S_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // Leaving at mid-stop-bit allows back-to-back frames.
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            done    <= 1'b1;
            done_ok <= line;
            state   <= line ? S_IDLE : S_BREAK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // The sample that ends the break counts as the first high of ARM.
        S_BREAK: begin
          if (line) begin
            cnt   <= CNT_W'(1);
            state <= S_ARM;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_ARM;
        end
      endcase
    end
  end

  // Command decode, cursor update and strobes, one cycle after the stop sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cursor_x    <= X_CTR;
      cursor_y    <= Y_CTR;
      cmd_valid   <= 1'b0;
      cmd         <= '0;
      click       <= 1'b0;
      scroll_up   <= 1'b0;
      scroll_down <= 1'b0;
      bad_cmd     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      cmd_valid   <= done & done_ok;
      frame_err   <= done & ~done_ok;
      click       <= 1'b0;
      scroll_up   <= 1'b0;
      scroll_down <= 1'b0;
      bad_cmd     <= 1'b0;
      if (done && done_ok) begin
        cmd <= shreg;
        case (shreg)
          8'd0:    cursor_y    <= sat_dec(cursor_y);
          8'd1:    cursor_y    <= sat_inc(cursor_y, Y_MAX);
          8'd2:    cursor_x    <= sat_dec(cursor_x);
          8'd3:    cursor_x    <= sat_inc(cursor_x, X_MAX);
          8'd4:    click       <= 1'b1;
          8'd6:    scroll_up   <= 1'b1;
          8'd7:    scroll_down <= 1'b1;
          8'd8: begin
            cursor_x <= X_CTR;
            cursor_y <= Y_CTR;
          end
          default: bad_cmd     <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: doc/glove_rx_decoder.md
# glove_rx_decoder

Host-side receiver for the glove command link. It deserializes the 8N1 UART stream that the glove transmitter emits on its `master_rx` line and decodes each command byte (0–8). It then maintains a saturating on-screen cursor position and produces single-cycle click and scroll strobes for the display/mouse logic downstream.

## Interface

Parameters:
- `CLK_FREQ`, 100_000_000: system clock in Hz.
- `BAUD`, 115200: line rate; `CLKS_PER_BIT = CLK_FREQ / BAUD` (integer division, 868 at defaults).
- `SCREEN_W`, 640: cursor X range is 0..SCREEN_W-1.
- `SCREEN_H`, 480: cursor Y range is 0..SCREEN_H-1.
- `STEP`, 4: pixels moved per direction command.

Ports:
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-low reset (asserted when 0).
- `rx`  input  1  asynchronous serial input; idle high.
- `cursor_x`  output  10  cursor column, registered.
- `cursor_y`  output  10  cursor row, registered.
- `cmd_valid`  output  1  one-cycle strobe: a well-formed byte was received.
- `cmd`  output  8  last received byte; only meaningful while `cmd_valid` is 1.
- `click`  output  1  one-cycle strobe on command 4.
- `scroll_up`  output  1  one-cycle strobe on command 6.
- `scroll_down`  output  1  one-cycle strobe on command 7.
- `bad_cmd`  output  1  one-cycle strobe when a framed byte is 5 or greater than 8.
- `frame_err`  output  1  one-cycle strobe when the stop bit is sampled as 0.

## Operation

- `rx` passes through a 2-flop synchronizer. All references to "line" below mean the synchronized signal.
- The receiver FSM has five states: ARM, IDLE, START, DATA, STOP, plus a BREAK state.
  - ARM (the reset state): stay until the line has been high for CLKS_PER_BIT consecutive cycles, then go to IDLE. Any low sample restarts the count.
  - IDLE: a low line starts the bit counter and moves to START.
  - START: at CLKS_PER_BIT/2, if the line is still low, clear the counter and go to DATA. Otherwise it was a glitch: return to IDLE with no outputs.
  - DATA: sample at every CLKS_PER_BIT count, LSB first. After 8 bits, go to STOP.
  - STOP: sample at CLKS_PER_BIT.
    - If the sample is 1: the byte is framed. Go to IDLE.
    - If the sample is 0: pulse `frame_err`, drop the byte, and go to BREAK.
  - BREAK: wait for the line to go high, then go to ARM.
- Decode of a framed byte:
  - 0: `cursor_y` decreases by STEP (up).
  - 1: `cursor_y` increases by STEP (down).
  - 2: `cursor_x` decreases by STEP (left).
  - 3: `cursor_x` increases by STEP (right).
  - 4: `click`.
  - 6: `scroll_up`.
  - 7: `scroll_down`.
  - 8: cursor set to (SCREEN_W/2, SCREEN_H/2).
  - 5 and 9..255: `bad_cmd` pulses and no other state changes.
- `cmd_valid` and `cmd` are asserted for every framed byte, including bad ones.
- Cursor arithmetic uses 11-bit intermediates with saturation:
  - decrement: if value < STEP, the result is 0; otherwise value − STEP.
  - increment: if value + STEP > LIMIT−1, the result is LIMIT−1; otherwise value + STEP.
- Only one command is decoded per byte, so simultaneous X and Y updates cannot occur.

## Timing

Reset values (`rst` = 0 at a clock edge):
- FSM goes to ARM.
- `cursor_x` = SCREEN_W/2 (320) and `cursor_y` = SCREEN_H/2 (240).
- All strobes are 0 and `cmd` is 0.
- Reset mid-frame aborts the byte with no strobes.

Latency and strobe timing:
- The stop-bit sample happens at edge T. At edge T+1, `cmd_valid`, `cmd`, the decoded strobe, and the new cursor position are all visible. The strobes are high for exactly one cycle.
- `frame_err` is registered at T+1 in the same way.
- A start edge on `rx` reaches the FSM 2 cycles later, because of the synchronizer.
- One frame lasts 10·CLKS_PER_BIT cycles. Back-to-back bytes with no idle gap are received correctly, because STOP hands off to IDLE at the mid-stop-bit sample point.
- There is no backpressure. Downstream logic must accept a strobe in the cycle it is presented.

## Test plan

- Reset → `cursor_x`=320, `cursor_y`=240, all strobes 0. Hold `rx` high for 868 cycles, send 0x03 → exactly one `cmd_valid` with `cmd`=3, and `cursor_x`=324 one cycle after the stop-bit sample.
- From center, send 0x02 81 times → `cursor_x` reaches 0 after 80 bytes and stays 0. Then send 0x01 61 times → `cursor_y` saturates at 479.
- Send 0x04, 0x06, 0x07 back-to-back with no gap → `click`, `scroll_up`, `scroll_down` each high for one cycle, cursor unchanged. Then send 0x05 and 0xFF → `bad_cmd` twice, no cursor change.
- Send a frame with the stop bit driven 0, then hold `rx` low for 3 bit times → one `frame_err`, no `cmd_valid`. Release the line, wait one bit time, send 0x08 → cursor returns to (320, 240).
- Drive a 100-cycle low glitch on idle `rx` → no strobes, FSM returns to IDLE.
- Assert `rst` in the middle of DATA while `rx` is low and keep `rx` low for 2 bit times after release → no byte is received until the line has been high for 868 cycles. A following 0x00 → `cursor_y`=236.
